// File: rtl/lsu_sram_bridge_if.sv
// Interfaces used by the load/store access unit.
//
// lsu_core_if : MEM-stage request / WB-stage response channel.
//    master  = core  (drives req_*, resp_ready)
//    slave   = bridge (drives req_ready, resp_*)
//    req_valid/req_ready          request handshake
//    req_we, req_size,
//    req_unsigned, req_addr,
//    req_wdata, req_rd            request payload
//    resp_valid/resp_ready        response handshake
//    resp_rdata, resp_rd,
//    resp_ale, resp_err           response payload
//
// lsu_sram_if : two-phase addr_ok/data_ok SRAM-like data bus.
//    master  = bridge (drives request, write flag, strobes, address, data)
//    slave   = memory (drives addr_ok, data_ok, rdata)

interface lsu_core_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_ale;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output resp_ready,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_rd, resp_ale, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  resp_ready,
      output req_ready,
      output resp_valid, resp_rdata, resp_rd, resp_ale, resp_err
   );
endinterface

interface lsu_sram_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/lsu_sram_bridge.sv
// Load/store access unit between the core's MEM stage and the data SRAM bus.
// Takes one request at a time, steers store bytes onto the right lanes with
// matching strobes, runs the addr_ok/data_ok handshake, extends load data and
// hands back a single response (with misalign / timeout flags).
//
// Ports:
//    clk    : clock, everything on posedge
//    reset  : synchronous, active-high
//    core   : lsu_core_if.slave  (request in, response out)
//    sram   : lsu_sram_if.master (SRAM-like data bus)
// Parameter:
//    TIMEOUT_CYCLES : cycles allowed in DATA before an error response (1..65535)

module lsu_sram_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   lsu_core_if.slave  core,
   lsu_sram_if.master sram
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;

   logic        we_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [4:0]  rd_q;
   logic [31:0] rdata_q;
   logic        ale_q;
   logic        err_q;
   logic [15:0] timer_q;

   logic        accept;
   logic        misaligned;
   logic        timeout_hit;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;
   logic [31:0] store_wdata;
   logic [3:0]  store_wstrb;

   // Request acceptance and the misalignment check on the incoming request.
   // Size 3 falls into the word case.
   always_comb begin
      accept     = core.req_valid && (state == IDLE) && !reset;
      misaligned = 1'b0;
      case (core.req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = core.req_addr[0];
         default: misaligned = |core.req_addr[1:0];
      endcase
      timeout_hit = (timer_q == TIMEOUT_LAST);
   end

   // Load extraction from the raw bus word using the latched address/size.
   // Stores always return zero data.
   always_comb begin
      load_byte = sram.data_sram_rdata[7:0];
      case (addr_q[1:0])
         2'd0: load_byte = sram.data_sram_rdata[7:0];
         2'd1: load_byte = sram.data_sram_rdata[15:8];
         2'd2: load_byte = sram.data_sram_rdata[23:16];
         2'd3: load_byte = sram.data_sram_rdata[31:24];
         default: load_byte = sram.data_sram_rdata[7:0];
      endcase
      load_half = addr_q[1] ? sram.data_sram_rdata[31:16] : sram.data_sram_rdata[15:0];
      case (size_q)
         2'd0:    load_value = unsigned_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
         2'd1:    load_value = unsigned_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
         default: load_value = sram.data_sram_rdata;
      endcase
      if (we_q) begin
         load_value = 32'd0;
      end
   end

   // Store lane steering: data is replicated across lanes so the memory
   // only needs the strobes to pick the right bytes.
   always_comb begin
      case (size_q)
         2'd0: begin
            store_wdata = {4{wdata_q[7:0]}};
            store_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'd1: begin
            store_wdata = {2{wdata_q[15:0]}};
            store_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            store_wdata = wdata_q;
            store_wstrb = 4'b1111;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded outputs. Bus outputs depend only on
   // state and latched registers, so there is no path from SRAM inputs to
   // SRAM outputs. Stale data_ok in IDLE/RESP simply has no case arm.
   always_comb begin
      state_next            = state;
      core.req_ready        = 1'b0;
      core.resp_valid       = 1'b0;
      core.resp_rdata       = 32'd0;
      core.resp_rd          = 5'd0;
      core.resp_ale         = 1'b0;
      core.resp_err         = 1'b0;
      sram.data_sram_req    = 1'b0;
      sram.data_sram_wr     = 1'b0;
      sram.data_sram_wstrb  = 4'b0000;
      sram.data_sram_addr   = 32'd0;
      sram.data_sram_wdata  = 32'd0;

      case (state)
         IDLE: begin
            core.req_ready = !reset;
            if (accept) begin
               state_next = misaligned ? RESP : ADDR;
            end
         end
         ADDR: begin
            sram.data_sram_req  = 1'b1;
            sram.data_sram_wr   = we_q;
            sram.data_sram_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
               sram.data_sram_wstrb = store_wstrb;
               sram.data_sram_wdata = store_wdata;
            end
            if (sram.data_sram_addr_ok) begin
               state_next = sram.data_sram_data_ok ? RESP : DATA;
            end
         end
         DATA: begin
            if (sram.data_sram_data_ok || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            core.resp_valid = 1'b1;
            core.resp_rdata = rdata_q;
            core.resp_rd    = rd_q;
            core.resp_ale   = ale_q;
            core.resp_err   = err_q;
            if (core.resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, response capture and DATA-phase timeout counter.
   // The counter is cleared on the addr_ok that leads into DATA.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         unsigned_q <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rd_q       <= 5'd0;
         rdata_q    <= 32'd0;
         ale_q      <= 1'b0;
         err_q      <= 1'b0;
         timer_q    <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q       <= core.req_we;
                  size_q     <= core.req_size;
                  unsigned_q <= core.req_unsigned;
                  addr_q     <= core.req_addr;
                  wdata_q    <= core.req_wdata;
                  rd_q       <= core.req_rd;
                  rdata_q    <= 32'd0;
                  ale_q      <= misaligned;
                  err_q      <= 1'b0;
               end
            end
            ADDR: begin
               if (sram.data_sram_addr_ok) begin
                  timer_q <= 16'd0;
                  if (sram.data_sram_data_ok) begin
                     rdata_q <= load_value;
                  end
               end
            end
            DATA: begin
               if (sram.data_sram_data_ok) begin
                  rdata_q <= load_value;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Self-checking bench for lsu_sram_bridge: directed cases from the intended
// behaviour plus randomized transactions, all compared against a byte-level
// reference model and a per-transaction expected timeline.

module tb_lsu_sram_bridge;

   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   lsu_core_if coreBus ();
   lsu_sram_if sramBus ();

   lsu_sram_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .core  (coreBus),
      .sram  (sramBus)
   );

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          addrDelay;
      bit          sameCycle;
      int          dataWait;
      int          respDelay;
      logic [31:0] busRdata;
   } txn_t;

   // One comparison: counts it, reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: access width in bytes, alignment, lanes, extension.
   function automatic int sizeBytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit modelMisaligned(input logic [1:0] size, input logic [31:0] addr);
      int off = int'(addr % 4);
      return (off % sizeBytes(size)) != 0;
   endfunction

   function automatic logic [3:0] modelStrb(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] strb;
      int n   = sizeBytes(size);
      int off = int'(addr % 4);
      for (int i = 0; i < 4; i++) strb[i] = (i >= off) && (i < off + n);
      return strb;
   endfunction

   function automatic logic [31:0] modelBusWdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] busW;
      int n = sizeBytes(size);
      for (int i = 0; i < 4; i++) busW[8*i +: 8] = wdata[8*(i % n) +: 8];
      return busW;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
      logic [63:0] raw;
      int n   = sizeBytes(size);
      int off = int'(addr % 4);
      raw = ({32'd0, rdata} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
      if (n < 4 && !uns && (((raw >> (8 * n - 1)) & 64'd1) == 64'd1)) begin
         raw = raw - (64'd1 << (8 * n));
      end
      return raw[31:0];
   endfunction

   function automatic txn_t makeTxn(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                    input int addrDelay, input bit sameCycle, input int dataWait,
                                    input int respDelay, input logic [31:0] busRdata);
      txn_t t;
      t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata; t.rd = rd;
      t.addrDelay = addrDelay; t.sameCycle = sameCycle; t.dataWait = dataWait;
      t.respDelay = respDelay; t.busRdata = busRdata;
      return t;
   endfunction

   // Runs one full transaction from IDLE back to IDLE, driving the bus side
   // from the transaction's delays and checking every cycle against the
   // expected timeline. Called and returns at #1 after a rising edge.
   task automatic applyStimulus(input txn_t t, input string name);
      bit          mis       = modelMisaligned(t.size, t.addr);
      int          addrEnd   = 1 + t.addrDelay;
      int          dataEntry = addrEnd + 1;
      bit          timedOut  = !mis && !t.sameCycle && (t.dataWait >= TIMEOUT);
      int          respCycle;
      logic [31:0] expRdata;
      bit          busReq;

      if (mis)              respCycle = 1;
      else if (t.sameCycle) respCycle = addrEnd + 1;
      else if (timedOut)    respCycle = dataEntry + TIMEOUT;
      else                  respCycle = dataEntry + t.dataWait + 1;
      expRdata = (mis || t.we || timedOut) ? 32'd0 : modelLoad(t.size, t.uns, t.addr, t.busRdata);

      checkOutput({name, ".idle_ready"}, 32'(coreBus.req_ready), 32'd1);
      coreBus.req_valid    = 1'b1;
      coreBus.req_we       = t.we;
      coreBus.req_size     = t.size;
      coreBus.req_unsigned = t.uns;
      coreBus.req_addr     = t.addr;
      coreBus.req_wdata    = t.wdata;
      coreBus.req_rd       = t.rd;
      sramBus.data_sram_addr_ok = 1'b0;
      sramBus.data_sram_data_ok = 1'b0;

      for (int cyc = 1; cyc <= respCycle; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            coreBus.req_valid    = 1'b0;
            coreBus.req_we       = 1'($urandom);
            coreBus.req_size     = 2'($urandom);
            coreBus.req_addr     = $urandom;
            coreBus.req_wdata    = $urandom;
            coreBus.req_rd       = 5'($urandom);
         end
         if (cyc < respCycle) begin
            checkOutput({name, ".resp_valid_wait"}, 32'(coreBus.resp_valid), 32'd0);
            checkOutput({name, ".req_ready_busy"}, 32'(coreBus.req_ready), 32'd0);
            busReq = !mis && (cyc <= addrEnd);
            checkOutput({name, ".sram_req"}, 32'(sramBus.data_sram_req), 32'(busReq));
            if (busReq) begin
               checkOutput({name, ".sram_addr"}, sramBus.data_sram_addr, {t.addr[31:2], 2'b00});
               checkOutput({name, ".sram_wr"}, 32'(sramBus.data_sram_wr), 32'(t.we));
               checkOutput({name, ".sram_wstrb"}, 32'(sramBus.data_sram_wstrb),
                           t.we ? 32'(modelStrb(t.size, t.addr)) : 32'd0);
               if (t.we) checkOutput({name, ".sram_wdata"}, sramBus.data_sram_wdata, modelBusWdata(t.size, t.wdata));
            end
            sramBus.data_sram_addr_ok = !mis && (cyc == addrEnd);
            sramBus.data_sram_data_ok = !mis && ((t.sameCycle && cyc == addrEnd) ||
                                        (!t.sameCycle && !timedOut && cyc == dataEntry + t.dataWait));
            sramBus.data_sram_rdata   = sramBus.data_sram_data_ok ? t.busRdata : $urandom;
         end
      end

      sramBus.data_sram_addr_ok = 1'b0;
      sramBus.data_sram_data_ok = 1'b0;
      for (int k = 0; k <= t.respDelay; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         checkOutput({name, ".resp_valid"}, 32'(coreBus.resp_valid), 32'd1);
         checkOutput({name, ".resp_rdata"}, coreBus.resp_rdata, expRdata);
         checkOutput({name, ".resp_rd"}, 32'(coreBus.resp_rd), 32'(t.rd));
         checkOutput({name, ".resp_ale"}, 32'(coreBus.resp_ale), 32'(mis));
         checkOutput({name, ".resp_err"}, 32'(coreBus.resp_err), 32'(timedOut));
         checkOutput({name, ".req_ready_resp"}, 32'(coreBus.req_ready), 32'd0);
         checkOutput({name, ".sram_req_resp"}, 32'(sramBus.data_sram_req), 32'd0);
         coreBus.resp_ready = (k == t.respDelay);
      end

      @(posedge clk); #1;
      coreBus.resp_ready = 1'b0;
      checkOutput({name, ".resp_valid_clear"}, 32'(coreBus.resp_valid), 32'd0);
      checkOutput({name, ".resp_ale_clear"}, 32'(coreBus.resp_ale), 32'd0);
      checkOutput({name, ".resp_err_clear"}, 32'(coreBus.resp_err), 32'd0);
      checkOutput({name, ".req_ready_back"}, 32'(coreBus.req_ready), 32'd1);
   endtask

   // data_ok while idle must not produce a response or a bus request.
   task automatic applyStaleDataOk();
      sramBus.data_sram_data_ok = 1'b1;
      sramBus.data_sram_rdata   = $urandom;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         checkOutput("stale.resp_valid", 32'(coreBus.resp_valid), 32'd0);
         checkOutput("stale.req_ready", 32'(coreBus.req_ready), 32'd1);
         checkOutput("stale.sram_req", 32'(sramBus.data_sram_req), 32'd0);
      end
      sramBus.data_sram_data_ok = 1'b0;
   endtask

   // Reset asserted mid-transaction (DATA, or RESP with a pending response).
   task automatic applyResetMidway(input bit inResp, input string name);
      checkOutput({name, ".idle_ready"}, 32'(coreBus.req_ready), 32'd1);
      coreBus.req_valid = 1'b1; coreBus.req_we = 1'b0; coreBus.req_size = 2'd2;
      coreBus.req_unsigned = 1'b0; coreBus.req_addr = 32'h0000_0200; coreBus.req_rd = 5'd7;
      @(posedge clk); #1;
      coreBus.req_valid = 1'b0;
      checkOutput({name, ".sram_req"}, 32'(sramBus.data_sram_req), 32'd1);
      sramBus.data_sram_addr_ok = 1'b1;
      @(posedge clk); #1;
      sramBus.data_sram_addr_ok = 1'b0;
      checkOutput({name, ".sram_req_data"}, 32'(sramBus.data_sram_req), 32'd0);
      if (inResp) begin
         sramBus.data_sram_data_ok = 1'b1;
         sramBus.data_sram_rdata   = 32'hCAFE_F00D;
         @(posedge clk); #1;
         sramBus.data_sram_data_ok = 1'b0;
         checkOutput({name, ".resp_pending"}, 32'(coreBus.resp_valid), 32'd1);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput({name, ".rst_sram_req"}, 32'(sramBus.data_sram_req), 32'd0);
      checkOutput({name, ".rst_resp_valid"}, 32'(coreBus.resp_valid), 32'd0);
      checkOutput({name, ".rst_resp_rdata"}, coreBus.resp_rdata, 32'd0);
      checkOutput({name, ".rst_req_ready"}, 32'(coreBus.req_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput({name, ".post_req_ready"}, 32'(coreBus.req_ready), 32'd1);
      checkOutput({name, ".post_resp_valid"}, 32'(coreBus.resp_valid), 32'd0);
   endtask

   initial begin
      txn_t t;
      int   n;

      reset = 1'b1;
      coreBus.req_valid = 1'b0; coreBus.req_we = 1'b0; coreBus.req_size = 2'd0;
      coreBus.req_unsigned = 1'b0; coreBus.req_addr = 32'd0; coreBus.req_wdata = 32'd0;
      coreBus.req_rd = 5'd0; coreBus.resp_ready = 1'b0;
      sramBus.data_sram_addr_ok = 1'b0; sramBus.data_sram_data_ok = 1'b0; sramBus.data_sram_rdata = 32'd0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.req_ready", 32'(coreBus.req_ready), 32'd0);
      checkOutput("reset.resp_valid", 32'(coreBus.resp_valid), 32'd0);
      checkOutput("reset.sram_req", 32'(sramBus.data_sram_req), 32'd0);
      checkOutput("reset.sram_wstrb", 32'(sramBus.data_sram_wstrb), 32'd0);
      checkOutput("reset.sram_addr", sramBus.data_sram_addr, 32'd0);
      checkOutput("reset.resp_rdata", coreBus.resp_rdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset.ready_after", 32'(coreBus.req_ready), 32'd1);

      applyStimulus(makeTxn(1'b0, 2'd2, 1'b0, 32'h1C00_0008, 32'd0, 5'd3, 0, 1'b0, 0, 0, 32'h8765_4321), "ld_w");
      applyStimulus(makeTxn(1'b0, 2'd0, 1'b0, 32'h1C00_0003, 32'd0, 5'd4, 0, 1'b0, 0, 0, 32'h80FF_FFFF), "ld_b");
      applyStimulus(makeTxn(1'b0, 2'd0, 1'b1, 32'h1C00_0003, 32'd0, 5'd5, 0, 1'b0, 0, 0, 32'h80FF_FFFF), "ld_bu");
      applyStimulus(makeTxn(1'b0, 2'd1, 1'b0, 32'h1C00_0002, 32'd0, 5'd6, 0, 1'b0, 0, 0, 32'h7F00_1234), "ld_h");
      applyStimulus(makeTxn(1'b1, 2'd0, 1'b0, 32'h1C00_0002, 32'h0000_00AB, 5'd7, 0, 1'b0, 0, 0, 32'd0), "st_b");
      applyStimulus(makeTxn(1'b1, 2'd1, 1'b0, 32'h1C00_0002, 32'h0000_1234, 5'd8, 0, 1'b0, 0, 0, 32'd0), "st_h");
      applyStimulus(makeTxn(1'b0, 2'd2, 1'b0, 32'h1C00_0006, 32'd0, 5'd9, 0, 1'b0, 0, 0, 32'hFFFF_FFFF), "ld_w_ale");
      applyStimulus(makeTxn(1'b1, 2'd2, 1'b0, 32'h1C00_0010, 32'hDEAD_BEEF, 5'd10, 3, 1'b0, 1, 2, 32'd0), "st_w_slow");
      applyStimulus(makeTxn(1'b0, 2'd1, 1'b1, 32'h1C00_0012, 32'd0, 5'd11, 0, 1'b1, 0, 1, 32'h9ABC_5678), "ld_hu_same");
      applyStimulus(makeTxn(1'b0, 2'd3, 1'b1, 32'h1C00_0020, 32'd0, 5'd12, 1, 1'b0, TIMEOUT, 0, 32'h1111_2222), "ld_timeout");
      applyStaleDataOk();
      applyStimulus(makeTxn(1'b0, 2'd3, 1'b1, 32'h1C00_0024, 32'd0, 5'd13, 0, 1'b0, TIMEOUT - 1, 0, 32'h8000_0001), "ld_last_cycle");
      applyResetMidway(1'b0, "rst_data");
      applyResetMidway(1'b1, "rst_resp");

      for (int i = 0; i < 60; i++) begin
         t.we        = 1'($urandom);
         t.size      = 2'($urandom_range(0, 3));
         t.uns       = 1'($urandom);
         t.addr      = $urandom;
         n           = sizeBytes(t.size);
         if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~32'(n - 1);
         t.wdata     = $urandom;
         t.rd        = 5'($urandom);
         t.addrDelay = $urandom_range(0, 3);
         t.sameCycle = ($urandom_range(0, 3) == 0);
         t.dataWait  = $urandom_range(0, TIMEOUT + 1);
         t.respDelay = $urandom_range(0, 2);
         t.busRdata  = $urandom;
         applyStimulus(t, $sformatf("rand%0d", i));
         if ($urandom_range(0, 4) == 0) applyStaleDataOk();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
